// File: rtl/byte_array_seq_pkg.sv
// Shared types and sizing for the byte array sequencer.
package byte_array_seq_pkg;

    localparam int unsigned BYTE_COUNT = 4;
    localparam int unsigned BYTE_WIDTH = 8;
    localparam int unsigned LANE_WIDTH = 2;
    localparam int unsigned WORD_WIDTH = BYTE_COUNT * BYTE_WIDTH;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EMIT  = 2'd2
    } seq_state_t;

    // Maps an order position to a lane (and back): reversal is a bitwise invert on 2 bits.
    function automatic logic [LANE_WIDTH-1:0] lane_at(input logic [LANE_WIDTH-1:0] pos,
                                                      input bit msb_first);
        return msb_first ? ~pos : pos;
    endfunction

endpackage

// File: rtl/byte_mask_next_lane.sv
// Picks the first (start=1) or the following (start=0) enabled lane in the configured order.
module byte_mask_next_lane
    import byte_array_seq_pkg::*;
#(
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic [BYTE_COUNT-1:0] mask,
    input  logic [LANE_WIDTH-1:0] lane,
    input  logic                  start,
    output logic [LANE_WIDTH-1:0] next_lane,
    output logic                  none_left
);

    localparam int unsigned POS_WIDTH = LANE_WIDTH + 1;

    logic [POS_WIDTH-1:0]  start_pos;
    logic [LANE_WIDTH-1:0] cand;

    // Scan order positions from last to first so the earliest qualifying position wins.
    always_comb begin
        next_lane = '0;
        none_left = 1'b1;
        cand      = '0;
        start_pos = start ? '0 : (POS_WIDTH'(lane_at(lane, MSB_FIRST)) + POS_WIDTH'(1));
        for (int p = BYTE_COUNT - 1; p >= 0; p--) begin
            cand = lane_at(LANE_WIDTH'(p), MSB_FIRST);
            if ((POS_WIDTH'(p) >= start_pos) && mask[cand]) begin
                next_lane = cand;
                none_left = 1'b0;
            end
        end
    end

endmodule

// File: rtl/byte_array_sequencer.sv
// Loads 32-bit words into the byte array processor and drains enabled lanes as a byte stream.
module byte_array_sequencer
    import byte_array_seq_pkg::*;
#(
    parameter bit          MSB_FIRST   = 1'b0,
    parameter int unsigned COUNT_WIDTH = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   word_valid,
    input  logic [WORD_WIDTH-1:0]  word_data,
    input  logic [BYTE_COUNT-1:0]  word_byte_mask,
    output logic                   word_ready,
    output logic                   proc_write_enable,
    output logic [WORD_WIDTH-1:0]  proc_data_word,
    output logic [LANE_WIDTH-1:0]  proc_byte_select,
    input  logic [BYTE_WIDTH-1:0]  proc_selected_byte,
    input  logic                   proc_byte_parity,
    output logic                   byte_valid,
    output logic [BYTE_WIDTH-1:0]  byte_data,
    output logic                   byte_parity,
    output logic [LANE_WIDTH-1:0]  byte_index,
    output logic                   byte_last,
    output logic                   word_parity,
    input  logic                   byte_ready,
    output logic                   busy,
    output logic [COUNT_WIDTH-1:0] words_done
);

    seq_state_t            state;
    logic [LANE_WIDTH-1:0] lane;
    logic [BYTE_COUNT-1:0] mask_q;
    logic                  parity_acc;

    logic [BYTE_COUNT-1:0] scan_mask;
    logic                  scan_start;
    logic [LANE_WIDTH-1:0] scan_next;
    logic                  scan_none;

    // In IDLE the scanner looks at the incoming mask for the first lane; otherwise it advances.
    assign scan_mask  = (state == IDLE) ? word_byte_mask : mask_q;
    assign scan_start = (state == IDLE);

    byte_mask_next_lane #(
        .MSB_FIRST (MSB_FIRST)
    ) u_next_lane (
        .mask      (scan_mask),
        .lane      (lane),
        .start     (scan_start),
        .next_lane (scan_next),
        .none_left (scan_none)
    );

    // State-decoded handshake flags and the processor load path, live only in IDLE.
    assign word_ready        = (state == IDLE);
    assign busy              = (state != IDLE);
    assign byte_valid        = (state == EMIT);
    assign proc_write_enable = word_ready & word_valid;
    assign proc_data_word    = word_ready ? word_data : '0;
    assign word_parity       = parity_acc;

    // Sequencer FSM with registered byte outputs, lane pointer and word counter.
    always_ff @(posedge clock) begin
        if (reset) begin
            state            <= IDLE;
            lane             <= '0;
            mask_q           <= '0;
            parity_acc       <= 1'b0;
            proc_byte_select <= '0;
            byte_data        <= '0;
            byte_parity      <= 1'b0;
            byte_index       <= '0;
            byte_last        <= 1'b0;
            words_done       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (word_valid) begin
                        mask_q <= word_byte_mask;
                        if (!scan_none) begin
                            lane             <= scan_next;
                            proc_byte_select <= scan_next;
                            state            <= FETCH;
                        end
                    end
                end
                FETCH: begin
                    byte_data   <= proc_selected_byte;
                    byte_parity <= proc_byte_parity;
                    byte_index  <= lane;
                    byte_last   <= scan_none;
                    parity_acc  <= parity_acc ^ proc_byte_parity;
                    if (!scan_none) begin
                        lane <= scan_next;
                    end
                    state <= EMIT;
                end
                EMIT: begin
                    if (byte_ready) begin
                        if (byte_last) begin
                            words_done <= words_done + COUNT_WIDTH'(1);
                            parity_acc <= 1'b0;
                            state      <= IDLE;
                        end else begin
                            proc_byte_select <= lane;
                            state            <= FETCH;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_byte_array_sequencer.sv
// Bench for byte_array_sequencer: two instances (LSB-first/16-bit count, MSB-first/2-bit count)
// share stimulus, each paired with a behavioural byte array processor.
module tb_byte_array_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        word_valid;
    logic [31:0] word_data;
    logic [3:0]  word_byte_mask;
    logic        byte_ready;

    logic        a_word_ready, a_we, a_pbp, a_byte_valid, a_byte_parity, a_byte_last, a_word_parity, a_busy;
    logic [31:0] a_pdw;
    logic [1:0]  a_sel, a_byte_index;
    logic [7:0]  a_psb, a_byte_data;
    logic [15:0] a_words_done;

    logic        b_word_ready, b_we, b_pbp, b_byte_valid, b_byte_parity, b_byte_last, b_word_parity, b_busy;
    logic [31:0] b_pdw;
    logic [1:0]  b_sel, b_byte_index;
    logic [7:0]  b_psb, b_byte_data;
    logic [1:0]  b_words_done;

    logic [31:0] store_a, store_b;

    typedef struct {
        logic [7:0] data;
        logic       par;
        logic [1:0] idx;
        logic       last;
        logic       wpar;
        int         stamp;
    } rec_t;

    rec_t got_a[$], got_b[$], exp_a[$], exp_b[$];
    int cyc = 0;
    int checks = 0;
    int failures = 0;
    int exp_done_a = 0;
    int exp_done_b = 0;

    always #5 clk = ~clk;

    byte_array_sequencer #(.MSB_FIRST(1'b0), .COUNT_WIDTH(16)) dut_a (
        .clock(clk), .reset(reset), .word_valid(word_valid), .word_data(word_data),
        .word_byte_mask(word_byte_mask), .word_ready(a_word_ready), .proc_write_enable(a_we),
        .proc_data_word(a_pdw), .proc_byte_select(a_sel), .proc_selected_byte(a_psb),
        .proc_byte_parity(a_pbp), .byte_valid(a_byte_valid), .byte_data(a_byte_data),
        .byte_parity(a_byte_parity), .byte_index(a_byte_index), .byte_last(a_byte_last),
        .word_parity(a_word_parity), .byte_ready(byte_ready), .busy(a_busy),
        .words_done(a_words_done)
    );

    byte_array_sequencer #(.MSB_FIRST(1'b1), .COUNT_WIDTH(2)) dut_b (
        .clock(clk), .reset(reset), .word_valid(word_valid), .word_data(word_data),
        .word_byte_mask(word_byte_mask), .word_ready(b_word_ready), .proc_write_enable(b_we),
        .proc_data_word(b_pdw), .proc_byte_select(b_sel), .proc_selected_byte(b_psb),
        .proc_byte_parity(b_pbp), .byte_valid(b_byte_valid), .byte_data(b_byte_data),
        .byte_parity(b_byte_parity), .byte_index(b_byte_index), .byte_last(b_byte_last),
        .word_parity(b_word_parity), .byte_ready(byte_ready), .busy(b_busy),
        .words_done(b_words_done)
    );

    // Behavioural byte array processors: word storage, byte mux and parity.
    always @(posedge clk) begin
        if (a_we) store_a <= a_pdw;
        if (b_we) store_b <= b_pdw;
    end
    assign a_psb = store_a[{a_sel, 3'b000} +: 8];
    assign b_psb = store_b[{b_sel, 3'b000} +: 8];
    assign a_pbp = ^a_psb;
    assign b_pbp = ^b_psb;

    // Stream monitor: record every byte handshake with the edge count it happened on.
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (!reset && byte_ready) begin
            if (a_byte_valid)
                got_a.push_back('{a_byte_data, a_byte_parity, a_byte_index, a_byte_last, a_word_parity, cyc});
            if (b_byte_valid)
                got_b.push_back('{b_byte_data, b_byte_parity, b_byte_index, b_byte_last, b_word_parity, cyc});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference stream for both lane orders, straight from mask and byte arithmetic.
    task automatic build_expected(input logic [31:0] w, input logic [3:0] m);
        logic [7:0] bv;
        logic       wp;
        int         ln;
        rec_t       r;
        exp_a.delete();
        exp_b.delete();
        for (int d = 0; d < 2; d++) begin
            wp = 1'b0;
            for (int k = 0; k < 4; k++) begin
                ln = (d == 1) ? 3 - k : k;
                if (m[ln]) begin
                    bv = w[ln*8 +: 8];
                    wp = wp ^ (^bv);
                    r = '{bv, ^bv, 2'(ln), 1'b0, wp, 0};
                    if (d == 1) exp_b.push_back(r);
                    else exp_a.push_back(r);
                end
            end
        end
        if (exp_a.size() > 0) exp_a[exp_a.size()-1].last = 1'b1;
        if (exp_b.size() > 0) exp_b[exp_b.size()-1].last = 1'b1;
    endtask

    // Send one word and drain it; stall_pct randomises byte_ready, hold stalls byte 2 for 5 cycles.
    task automatic test_stream(input logic [31:0] w, input logic [3:0] m, input int stall_pct,
                               input bit hold);
        int   n, held, accept_cyc;
        rec_t g, e;
        int   gsz, esz;
        build_expected(w, m);
        got_a.delete();
        got_b.delete();
        checks++;
        if (a_word_ready !== 1'b1 || b_word_ready !== 1'b1) begin
            failures++;
            $display("FAIL word_ready_idle: got %b/%b want 1/1", a_word_ready, b_word_ready);
        end
        word_valid = 1'b1; word_data = w; word_byte_mask = m; byte_ready = 1'b1;
        tick();
        accept_cyc = cyc;
        word_valid = 1'b0; word_data = $urandom; word_byte_mask = 4'($urandom);
        n = 0; held = 0;
        while ((a_busy || b_busy) && n < 300) begin
            if (hold && got_a.size() == 1 && a_byte_valid && held < 5) begin
                byte_ready = 1'b0;
                held++;
                checks++;
                if ({a_byte_data, a_byte_parity, a_byte_index} !== {exp_a[1].data, exp_a[1].par, exp_a[1].idx}) begin
                    failures++;
                    $display("FAIL held_byte: got %h/%b/%0d want %h/%b/%0d", a_byte_data, a_byte_parity,
                             a_byte_index, exp_a[1].data, exp_a[1].par, exp_a[1].idx);
                end
            end else begin
                byte_ready = ($urandom_range(0, 99) >= 32'(stall_pct));
            end
            tick();
            n++;
        end
        byte_ready = 1'b1;
        checks++;
        if (n >= 300) begin
            failures++;
            $display("FAIL drain_timeout: busy %b/%b after %0d cycles want 0/0", a_busy, b_busy, n);
        end
        if (hold) begin
            checks++;
            if (held != 5) begin
                failures++;
                $display("FAIL hold_cycles: got %0d want 5", held);
            end
        end
        if (m != 4'b0000) begin
            exp_done_a++;
            exp_done_b++;
        end
        for (int d = 0; d < 2; d++) begin
            gsz = (d == 1) ? got_b.size() : got_a.size();
            esz = (d == 1) ? exp_b.size() : exp_a.size();
            checks++;
            if (gsz != esz) begin
                failures++;
                $display("FAIL byte_count dut%0d word %h mask %b: got %0d want %0d", d, w, m, gsz, esz);
            end
            for (int i = 0; i < esz && i < gsz; i++) begin
                g = (d == 1) ? got_b[i] : got_a[i];
                e = (d == 1) ? exp_b[i] : exp_a[i];
                checks++;
                if ({g.data, g.par, g.idx, g.last} !== {e.data, e.par, e.idx, e.last}) begin
                    failures++;
                    $display("FAIL byte dut%0d #%0d: got data %h par %b idx %0d last %b want %h %b %0d %b",
                             d, i, g.data, g.par, g.idx, g.last, e.data, e.par, e.idx, e.last);
                end
                if (e.last) begin
                    checks++;
                    if (g.wpar !== e.wpar) begin
                        failures++;
                        $display("FAIL word_parity dut%0d: got %b want %b", d, g.wpar, e.wpar);
                    end
                end
                if (stall_pct == 0 && !hold) begin
                    checks++;
                    if (g.stamp != accept_cyc + 2 * (i + 1)) begin
                        failures++;
                        $display("FAIL timing dut%0d #%0d: got edge %0d want %0d", d, i, g.stamp,
                                 accept_cyc + 2 * (i + 1));
                    end
                end
            end
        end
        checks++;
        if (a_words_done !== 16'(exp_done_a) || b_words_done !== 2'(exp_done_b % 4)) begin
            failures++;
            $display("FAIL words_done: got %0d/%0d want %0d/%0d", a_words_done, b_words_done,
                     exp_done_a, exp_done_b % 4);
        end
        checks++;
        if (a_word_ready !== 1'b1 || a_byte_valid !== 1'b0 || b_byte_valid !== 1'b0) begin
            failures++;
            $display("FAIL back_to_idle: ready %b valid %b/%b want 1 0/0", a_word_ready, a_byte_valid, b_byte_valid);
        end
    endtask

    task automatic apply_reset();
        reset = 1'b1; word_valid = 1'b0; byte_ready = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        exp_done_a = 0;
        exp_done_b = 0;
    endtask

    task automatic test_reset();
        reset = 1'b1; word_valid = 1'b0; byte_ready = 1'b0; word_data = '0; word_byte_mask = '0;
        tick();
        tick();
        checks++;
        if ({a_word_ready, a_busy, a_byte_valid, a_we, a_byte_last, a_word_parity, a_byte_parity} !== 7'b1000000) begin
            failures++;
            $display("FAIL reset_flags: got %b want 1000000", {a_word_ready, a_busy, a_byte_valid,
                     a_we, a_byte_last, a_word_parity, a_byte_parity});
        end
        checks++;
        if ({a_byte_data, a_byte_index, a_sel, a_pdw} !== 44'h0 || a_words_done !== 16'h0 || b_words_done !== 2'h0) begin
            failures++;
            $display("FAIL reset_values: data %h idx %0d sel %0d pdw %h done %0d/%0d want all 0", a_byte_data,
                     a_byte_index, a_sel, a_pdw, a_words_done, b_words_done);
        end
        reset = 1'b0;
        byte_ready = 1'b1;
        tick();
        checks++;
        if (a_busy !== 1'b0 || b_busy !== 1'b0) begin
            failures++;
            $display("FAIL idle_after_reset: busy %b/%b want 0/0", a_busy, b_busy);
        end
    endtask

    task automatic test_full_mask();
        test_stream(32'hA1B2C3D4, 4'b1111, 0, 1'b0);
        checks++;
        if (got_a.size() != 4 || got_a[0].data !== 8'hD4 || got_a[3].data !== 8'hA1 || got_a[3].wpar !== 1'b1) begin
            failures++;
            $display("FAIL full_mask_endpoints: size %0d want 4 first D4 last A1 word_parity 1", got_a.size());
        end
    endtask

    task automatic test_sparse_mask();
        test_stream(32'h11223344, 4'b1010, 0, 1'b0);
        checks++;
        if (got_b.size() != 2 || got_b[0].data !== 8'h11 || got_b[0].idx !== 2'd3 || got_b[1].data !== 8'h33
            || got_b[1].idx !== 2'd1 || got_b[1].last !== 1'b1 || got_b[1].wpar !== 1'b0) begin
            failures++;
            $display("FAIL sparse_msb_first: size %0d want 2 (11@3, 33@1 last, word_parity 0)", got_b.size());
        end
    endtask

    task automatic test_zero_mask();
        test_stream(32'hFFFFFFFF, 4'b0000, 0, 1'b0);
        tick();
        checks++;
        if (a_word_ready !== 1'b1 || a_byte_valid !== 1'b0 || a_busy !== 1'b0) begin
            failures++;
            $display("FAIL zero_mask: ready %b valid %b busy %b want 1 0 0", a_word_ready, a_byte_valid, a_busy);
        end
    endtask

    task automatic test_backpressure();
        test_stream(32'h0000FF00, 4'b1111, 0, 1'b1);
    endtask

    task automatic test_reset_mid_word();
        int n;
        got_a.delete();
        got_b.delete();
        word_valid = 1'b1; word_data = $urandom; word_byte_mask = 4'b1111; byte_ready = 1'b1;
        tick();
        word_valid = 1'b0;
        n = 0;
        while (got_a.size() < 2 && n < 50) begin tick(); n++; end
        byte_ready = 1'b0;
        while (!a_byte_valid && n < 50) begin tick(); n++; end
        checks++;
        if (a_byte_valid !== 1'b1 || a_byte_index !== 2'd2) begin
            failures++;
            $display("FAIL reach_lane2: valid %b idx %0d want 1 2", a_byte_valid, a_byte_index);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if ({a_busy, a_byte_valid, a_word_ready, a_word_parity, b_byte_valid} !== 5'b00100
            || a_words_done !== 16'h0 || a_sel !== 2'd0) begin
            failures++;
            $display("FAIL reset_mid_word: busy %b valid %b ready %b wpar %b done %0d sel %0d want 0 0 1 0 0 0",
                     a_busy, a_byte_valid, a_word_ready, a_word_parity, a_words_done, a_sel);
        end
        exp_done_a = 0;
        exp_done_b = 0;
        test_stream(32'h5A6B7C8D, 4'b0110, 0, 1'b0);
    endtask

    task automatic test_wrap();
        logic [1:0] wrap_tab [5];
        wrap_tab = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        apply_reset();
        byte_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            test_stream($urandom, 4'(1 << $urandom_range(0, 3)), 0, 1'b0);
            checks++;
            if (b_words_done !== wrap_tab[k] || a_words_done !== 16'(k + 1)) begin
                failures++;
                $display("FAIL wrap #%0d: got %0d/%0d want %0d/%0d", k, b_words_done, a_words_done,
                         wrap_tab[k], k + 1);
            end
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 25; k++) begin
            test_stream($urandom, 4'($urandom_range(0, 15)), 40, 1'b0);
        end
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 6; k++) begin
            test_stream($urandom, 4'($urandom_range(1, 15)), 0, 1'b0);
        end
    endtask

    initial begin
        test_reset();
        test_full_mask();
        test_sparse_mask();
        test_zero_mask();
        test_backpressure();
        test_reset_mid_word();
        test_wrap();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/byte_array_sequencer.md
# byte_array_sequencer

Controller that feeds the byte array processor datapath and drains it as a byte stream. It accepts 32-bit words over a valid/ready handshake and loads each word into the processor's storage. It then steps the processor's byte select through the enabled byte lanes and emits each selected byte with its parity over a second valid/ready handshake. It sits between a word-oriented upstream source and a byte-oriented downstream consumer, and is the only driver of the processor's write enable, data word and byte select.

## Interface
Parameters:
- MSB_FIRST, 0, lane order: 0 = lane 0→3, 1 = lane 3→0
- COUNT_WIDTH, 16, width of words_done counter

Ports:
- clock  in  1  single clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- word_valid  in  1  upstream word available
- word_data  in  32  word to process
- word_byte_mask  in  4  lane enables, bit i = lane i (bits [8i+7:8i])
- word_ready  out  1  sequencer can accept a word
- proc_write_enable  out  1  processor storage load strobe
- proc_data_word  out  32  processor data word
- proc_byte_select  out  2  processor lane select
- proc_selected_byte  in  8  processor selected byte
- proc_byte_parity  in  1  processor parity of selected byte
- byte_valid  out  1  output byte available
- byte_data  out  8  output byte
- byte_parity  out  1  even-parity bit (XOR) of byte_data
- byte_index  out  2  lane number of byte_data
- byte_last  out  1  final enabled lane of current word
- word_parity  out  1  XOR of all emitted byte parities of the word, valid with byte_last
- byte_ready  in  1  downstream accepts byte
- busy  out  1  high in any state other than IDLE
- words_done  out  COUNT_WIDTH  completed-word counter

## Operation
- FSM states: IDLE, FETCH, EMIT.
- IDLE:
  - word_ready = 1, derived from state only and never from word_valid.
  - proc_write_enable = word_valid, and proc_data_word = word_data combinationally, so processor storage loads on the accept edge.
  - Mask is captured on accept.
  - mask = 4'b0000: word consumed, nothing emitted, words_done unchanged, stay IDLE.
  - Nonzero mask: go to FETCH with the lane index = first enabled lane in the configured order.
- FETCH (exactly 1 cycle):
  - proc_byte_select = current lane.
  - On the edge, register proc_selected_byte → byte_data, proc_byte_parity → byte_parity, lane → byte_index.
  - Set byte_last if no further enabled lane remains.
  - Fold the parity into the word parity accumulator; go to EMIT.
- EMIT:
  - byte_valid = 1.
  - byte_data, byte_parity, byte_index, byte_last and word_parity are held stable until byte_valid && byte_ready.
  - On handshake with byte_last = 0: advance to the next enabled lane and go to FETCH.
  - On handshake with byte_last = 1: increment words_done, clear the accumulator, go to IDLE.
- Outside IDLE, proc_write_enable = 0 and proc_data_word = 0.
- proc_byte_select holds its last value outside FETCH.
- words_done wraps from all-ones to 0.
- Reset (any state, mid-word included):
  - Next cycle the FSM is in IDLE; any in-flight byte and word are discarded.
  - All outputs are 0 except word_ready = 1.
  - words_done = 0, accumulator = 0, proc_byte_select = 0.

## Timing
- Word accepted at edge N → FETCH during cycle N+1 → byte_valid high from cycle N+2.
- Per enabled byte, with byte_ready tied high: 2 cycles (FETCH + EMIT).
- Full-mask word with no backpressure: 4 bytes in 8 cycles. word_ready returns high the cycle after the last handshake.
- Backpressure: each cycle with byte_ready = 0 in EMIT adds one cycle; there are no bubbles otherwise.
- byte_ready while byte_valid = 0 is ignored.
- word_valid while word_ready = 0 is ignored; upstream must hold the word.

## Structure
- Package byte_array_seq_pkg holds:
  - typedef enum logic [1:0] seq_state_t {IDLE, FETCH, EMIT}
  - localparams BYTE_COUNT = 4, BYTE_WIDTH = 8, LANE_WIDTH = 2
- One sub-module, byte_mask_next_lane (combinational):
  - Inputs: mask, current lane, MSB_FIRST, and a "start" flag.
  - Outputs: next enabled lane and a none_left flag.
  - Used both for the first-lane choice in IDLE and for the advance/last decision in FETCH.
- Top-level testbench instantiates byte_array_sequencer together with byte_array_processor.

## Test plan
- Full mask, MSB_FIRST=0, word 32'hA1B2C3D4, byte_ready=1 → byte stream:
  - D4 p0 idx0, C3 p0 idx1, B2 p0 idx2, A1 p1 idx3 with byte_last
  - word_parity=1, bytes 2 cycles apart, words_done=1
- Mask 4'b1010, MSB_FIRST=1, word 32'h11223344 → 11 idx3, then 33 idx1 with byte_last=1 and word_parity=0; no other bytes.
- Mask 4'b0000 with word 32'hFFFFFFFF → word_ready stays 1, no byte_valid, words_done unchanged.
- Backpressure: byte_ready low for 5 cycles on the second byte of 32'h0000FF00 → byte_data=FF, byte_parity=0 and byte_index=1 held stable; the stream resumes with no loss or duplication.
- Reset asserted while in EMIT on lane 2 → next cycle IDLE, byte_valid=0, word_ready=1, words_done=0; the following word is processed from its first lane.
- Wrap: COUNT_WIDTH=2, 5 consecutive single-lane words → words_done sequence 1,2,3,0,1.
